// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the decode stage: instruction geometry,
// RV32/RV64 major opcodes, format class codes and the per-entry decode record.
package decode_stage_pkg;

    localparam int ILEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int OPCODE_LENGTH  = 7;

    localparam logic [OPCODE_LENGTH-1:0] OPC_LOAD      = 7'b0000011;
    localparam logic [OPCODE_LENGTH-1:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_LENGTH-1:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [OPCODE_LENGTH-1:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [OPCODE_LENGTH-1:0] OPC_STORE     = 7'b0100011;
    localparam logic [OPCODE_LENGTH-1:0] OPC_OP        = 7'b0110011;
    localparam logic [OPCODE_LENGTH-1:0] OPC_LUI       = 7'b0110111;
    localparam logic [OPCODE_LENGTH-1:0] OPC_OP_32     = 7'b0111011;
    localparam logic [OPCODE_LENGTH-1:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [OPCODE_LENGTH-1:0] OPC_JALR      = 7'b1100111;
    localparam logic [OPCODE_LENGTH-1:0] OPC_JAL       = 7'b1101111;
    localparam logic [OPCODE_LENGTH-1:0] OPC_SYSTEM    = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_INV = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [2:0]                func3;
        logic [6:0]                func7;
        logic [OPCODE_LENGTH-1:0]  opcode;
        fmt_e                      fmt;
        logic                      rs1_en;
        logic                      rs2_en;
        logic                      rd_en;
        logic                      illegal;
    } dec_fields_t;

    // The 32-bit-only opcodes (OP-32, OP-IMM-32) exist only on RV64 cores.
    function automatic fmt_e opcode_to_fmt(input logic [OPCODE_LENGTH-1:0] opc, input logic rv64);
        fmt_e f;
        case (opc)
            OPC_OP:                                    f = FMT_R;
            OPC_OP_32:                                 f = rv64 ? FMT_R : FMT_INV;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: f = FMT_I;
            OPC_OP_IMM_32:                             f = rv64 ? FMT_I : FMT_INV;
            OPC_STORE:                                 f = FMT_S;
            OPC_BRANCH:                                f = FMT_B;
            OPC_LUI, OPC_AUIPC:                        f = FMT_U;
            OPC_JAL:                                   f = FMT_J;
            default:                                   f = FMT_INV;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate builder. Every RISC-V immediate fits in a
// signed 32-bit value, so it is assembled at 32 bits and then sign-extended
// to XLEN. Only instr[31:7] carries immediate bits, so the opcode is not an input.
module imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [ILEN-1:OPCODE_LENGTH] instr,
    input  fmt_e                        fmt,
    output logic [XLEN-1:0]             imm
);

    logic signed [31:0] imm32;

    // Pick the immediate layout for the format, then sign-extend to XLEN.
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm = XLEN'(imm32);
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: buffered RV32/RV64 decode between fetch and execute.
// Incoming {pc, instr} pairs are decoded on the way in and stored in a
// DEPTH-entry FIFO; the head entry is held in output registers so every
// output is register-driven and holds its value while the FIFO is empty.
// Optional feature macro: DECODE_ILLEGAL_EN (illegal-instruction flagging).
module decode_stage #(
    parameter int XLEN        = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             rd,
    output logic [2:0]             func3,
    output logic [6:0]             func7,
    output logic [6:0]             opcode,
    output logic [XLEN-1:0]        imm,
    output logic [2:0]             fmt,
    output logic                   rs1_en,
    output logic                   rs2_en,
    output logic                   rd_en,
    output logic                   illegal
);
    import decode_stage_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic IS_RV64 = (XLEN == 64) ? 1'b1 : 1'b0;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    dec_fields_t      dec_mem [DEPTH];
    logic [XLEN-1:0]  pc_mem  [DEPTH];
    logic [XLEN-1:0]  imm_mem [DEPTH];

    dec_fields_t      in_dec;
    fmt_e             in_fmt;
    logic [XLEN-1:0]  in_imm;

    dec_fields_t      head_dec;
    logic [XLEN-1:0]  head_pc;
    logic [XLEN-1:0]  head_imm;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[ILEN-1:OPCODE_LENGTH]),
        .fmt   (in_fmt),
        .imm   (in_imm)
    );

    // Decode the incoming instruction into the record stored per FIFO entry.
    always_comb begin
        in_dec        = '0;
        in_fmt        = opcode_to_fmt(in_instr[6:0], IS_RV64);
        in_dec.rs1    = in_instr[19:15];
        in_dec.rs2    = in_instr[24:20];
        in_dec.rd     = in_instr[11:7];
        in_dec.func3  = in_instr[14:12];
        in_dec.func7  = in_instr[31:25];
        in_dec.opcode = in_instr[6:0];
        in_dec.fmt    = in_fmt;
        in_dec.rs1_en = in_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
        in_dec.rs2_en = in_fmt inside {FMT_R, FMT_S, FMT_B};
        in_dec.rd_en  = (in_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (in_instr[11:7] != 5'd0);
        in_dec.illegal = 1'b0;
`ifdef DECODE_ILLEGAL_EN
        // Only ECALL/EBREAK are accepted in the SYSTEM func3==0 space.
        if ((in_fmt == FMT_INV) ||
            ((in_instr[6:0] == OPC_SYSTEM) && (in_instr[14:12] == 3'd0) && (in_instr[31:20] > 12'd1))) begin
            in_dec.illegal = 1'b1;
            in_dec.rs1_en  = 1'b0;
            in_dec.rs2_en  = 1'b0;
            in_dec.rd_en   = 1'b0;
        end
`endif
    end

    // Handshake and next-state arithmetic; ready depends only on the stored count.
    always_comb begin
        in_ready   = (count != CNT_W'(DEPTH));
        out_valid  = (count != '0);
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
        rd_next    = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Store the decoded entry in its slot; a flushed or reset cycle writes nothing.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            dec_mem[wr_ptr] <= in_dec;
            pc_mem[wr_ptr]  <= in_pc;
            imm_mem[wr_ptr] <= in_imm;
        end
    end

    // Pointer/count control and the head output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_dec <= '0;
            head_pc  <= '0;
            head_imm <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            if (count_next != '0) begin
                if (push && (wr_ptr == rd_next)) begin
                    head_dec <= in_dec;
                    head_pc  <= in_pc;
                    head_imm <= in_imm;
                end else begin
                    head_dec <= dec_mem[rd_next];
                    head_pc  <= pc_mem[rd_next];
                    head_imm <= imm_mem[rd_next];
                end
            end
        end
    end

    // Outputs are taken straight from the head registers.
    always_comb begin
        out_pc  = head_pc;
        rs1     = head_dec.rs1;
        rs2     = head_dec.rs2;
        rd      = head_dec.rd;
        func3   = head_dec.func3;
        func7   = head_dec.func7;
        opcode  = head_dec.opcode;
        imm     = head_imm;
        fmt     = head_dec.fmt;
        rs1_en  = head_dec.rs1_en;
        rs2_en  = head_dec.rs2_en;
        rd_en   = head_dec.rd_en;
        illegal = head_dec.illegal;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: an RV32 and an RV64 instance (DEPTH=2) share
// their inputs. Directed scenarios plus a randomized run checked against a
// queue-based reference model of the FIFO and an arithmetic decode model.
module tb_decode_stage;

    localparam int DEPTH = 2;

`ifdef DECODE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_en;
        logic        illegal;
    } exp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;

    logic        in_ready_32, out_valid_32, rs1_en_32, rs2_en_32, rd_en_32, illegal_32;
    logic [31:0] out_pc_32, imm_32;
    logic [4:0]  rs1_32, rs2_32, rd_32;
    logic [2:0]  func3_32, fmt_32;
    logic [6:0]  func7_32, opcode_32;

    logic        in_ready_64, out_valid_64, rs1_en_64, rs2_en_64, rd_en_64, illegal_64;
    logic [63:0] out_pc_64, imm_64;
    logic [4:0]  rs1_64, rs2_64, rd_64;
    logic [2:0]  func3_64, fmt_64;
    logic [6:0]  func7_64, opcode_64;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [6:0] op_pool [14] = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73,
                                 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h7F};

    decode_stage #(.XLEN(32), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_32),
        .in_pc(in_pc[31:0]), .in_instr(in_instr), .out_valid(out_valid_32), .out_ready(out_ready),
        .out_pc(out_pc_32), .rs1(rs1_32), .rs2(rs2_32), .rd(rd_32), .func3(func3_32),
        .func7(func7_32), .opcode(opcode_32), .imm(imm_32), .fmt(fmt_32), .rs1_en(rs1_en_32),
        .rs2_en(rs2_en_32), .rd_en(rd_en_32), .illegal(illegal_32)
    );

    decode_stage #(.XLEN(64), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_64),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid_64), .out_ready(out_ready),
        .out_pc(out_pc_64), .rs1(rs1_64), .rs2(rs2_64), .rd(rd_64), .func3(func3_64),
        .func7(func7_64), .opcode(opcode_64), .imm(imm_64), .fmt(fmt_64), .rs1_en(rs1_en_64),
        .rs2_en(rs2_en_64), .rd_en(rd_en_64), .illegal(illegal_64)
    );

    always #5 clk = ~clk;

    // Reference decode straight from the ISA rules, immediates built arithmetically.
    function automatic exp_t model_decode(input logic [31:0] ins, input bit is64);
        exp_t e;
        e = '0;
        case (ins[6:0])
            7'h33:                      e.fmt = 3'd0;
            7'h3B:                      e.fmt = is64 ? 3'd0 : 3'd7;
            7'h13, 7'h03, 7'h67, 7'h73: e.fmt = 3'd1;
            7'h1B:                      e.fmt = is64 ? 3'd1 : 3'd7;
            7'h23:                      e.fmt = 3'd2;
            7'h63:                      e.fmt = 3'd3;
            7'h37, 7'h17:               e.fmt = 3'd4;
            7'h6F:                      e.fmt = 3'd5;
            default:                    e.fmt = 3'd7;
        endcase
        case (e.fmt)
            3'd1: e.imm = longint'(ins[31:20]) - (ins[31] ? 64'd4096 : 64'd0);
            3'd2: e.imm = longint'({ins[31:25], ins[11:7]}) - (ins[31] ? 64'd4096 : 64'd0);
            3'd3: e.imm = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}) - (ins[31] ? 64'd8192 : 64'd0);
            3'd4: e.imm = longint'(ins[31:12]) * 64'd4096 - (ins[31] ? 64'h1_0000_0000 : 64'd0);
            3'd5: e.imm = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}) - (ins[31] ? 64'd2097152 : 64'd0);
            default: e.imm = 64'd0;
        endcase
        e.rs1_en = (e.fmt <= 3'd3);
        e.rs2_en = (e.fmt == 3'd0) || (e.fmt == 3'd2) || (e.fmt == 3'd3);
        e.rd_en  = ((e.fmt == 3'd0) || (e.fmt == 3'd1) || (e.fmt == 3'd4) || (e.fmt == 3'd5)) && (ins[11:7] != 5'd0);
        if (ILL_EN && ((e.fmt == 3'd7) || (ins[6:0] == 7'h73 && ins[14:12] == 3'd0 && ins[31:20] > 12'd1))) begin
            e.illegal = 1'b1;
            e.rs1_en  = 1'b0;
            e.rs2_en  = 1'b0;
            e.rd_en   = 1'b0;
        end
        return e;
    endfunction

    // Drive one cycle of inputs from a negedge and return at the next negedge.
    task automatic tick(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        rst = 1'b0;
        n_cmp++; if (in_ready_32 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready_32); end
        n_cmp++; if (out_valid_32 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid_32); end
        n_cmp++; if ({out_pc_32, imm_32} !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_pc_imm: got %h %h want 0", out_pc_32, imm_32); end
        n_cmp++; if ({rs1_32, rs2_32, rd_32, func3_32, func7_32, opcode_32, fmt_32} !== 35'h0) begin n_fail++; $display("[TB] FAIL reset_fields: fmt %0d rd %0d want 0", fmt_32, rd_32); end
        n_cmp++; if ({rs1_en_32, rs2_en_32, rd_en_32, illegal_32} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 0000", {rs1_en_32, rs2_en_32, rd_en_32, illegal_32}); end
        n_cmp++; if ({out_valid_64, in_ready_64, imm_64} !== {2'b01, 64'h0}) begin n_fail++; $display("[TB] FAIL reset_rv64: valid %b ready %b imm %h", out_valid_64, in_ready_64, imm_64); end
    endtask

    task automatic test_addi();
        tick(1'b1, 32'h00500093, 64'h100, 1'b0, 1'b0);
        n_cmp++; if (out_valid_32 !== 1'b1) begin n_fail++; $display("[TB] FAIL addi_latency: out_valid %b want 1", out_valid_32); end
        n_cmp++; if ({fmt_32, rd_32, rs1_32} !== {3'd1, 5'd1, 5'd0}) begin n_fail++; $display("[TB] FAIL addi_fields: fmt %0d rd %0d rs1 %0d want 1 1 0", fmt_32, rd_32, rs1_32); end
        n_cmp++; if (imm_32 !== 32'd5) begin n_fail++; $display("[TB] FAIL addi_imm: got %h want 5", imm_32); end
        n_cmp++; if ({rd_en_32, rs2_en_32} !== 2'b10) begin n_fail++; $display("[TB] FAIL addi_en: rd_en %b rs2_en %b want 1 0", rd_en_32, rs2_en_32); end
        n_cmp++; if (out_pc_32 !== 32'h100) begin n_fail++; $display("[TB] FAIL addi_pc: got %h want 100", out_pc_32); end
        tick(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        n_cmp++; if ({out_valid_32, fmt_32, imm_32} !== {1'b0, 3'd1, 32'd5}) begin n_fail++; $display("[TB] FAIL empty_hold: valid %b fmt %0d imm %h want 0 1 5", out_valid_32, fmt_32, imm_32); end
    endtask

    task automatic test_sw();
        tick(1'b1, 32'hFE20AE23, 64'h104, 1'b0, 1'b0);
        n_cmp++; if ({fmt_32, rs1_32, rs2_32} !== {3'd2, 5'd1, 5'd2}) begin n_fail++; $display("[TB] FAIL sw_fields: fmt %0d rs1 %0d rs2 %0d want 2 1 2", fmt_32, rs1_32, rs2_32); end
        n_cmp++; if (imm_32 !== 32'hFFFFFFFC) begin n_fail++; $display("[TB] FAIL sw_imm: got %h want fffffffc", imm_32); end
        n_cmp++; if (rd_en_32 !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_rd_en: got %b want 0", rd_en_32); end
        tick(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);
    endtask

    task automatic test_full_backpressure();
        tick(1'b1, 32'h00700113, 64'h200, 1'b0, 1'b0);
        tick(1'b1, 32'h123451B7, 64'h204, 1'b0, 1'b0);
        n_cmp++; if ({in_ready_32, out_pc_32} !== {1'b0, 32'h200}) begin n_fail++; $display("[TB] FAIL full_ready: ready %b pc %h want 0 200", in_ready_32, out_pc_32); end
        tick(1'b1, 32'h00000013, 64'h208, 1'b0, 1'b0);
        n_cmp++; if ({in_ready_32, out_valid_32, out_pc_32, rd_32} !== {2'b01, 32'h200, 5'd2}) begin n_fail++; $display("[TB] FAIL full_stall: ready %b pc %h rd %0d want 0 200 2", in_ready_32, out_pc_32, rd_32); end
        tick(1'b1, 32'h00000013, 64'h208, 1'b1, 1'b0);
        n_cmp++; if ({in_ready_32, out_pc_32, rd_32, fmt_32} !== {1'b1, 32'h204, 5'd3, 3'd4}) begin n_fail++; $display("[TB] FAIL full_pop_order: ready %b pc %h rd %0d fmt %0d want 1 204 3 4", in_ready_32, out_pc_32, rd_32, fmt_32); end
        tick(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        n_cmp++; if (out_valid_32 !== 1'b0) begin n_fail++; $display("[TB] FAIL full_no_c: out_valid %b want 0 pc %h", out_valid_32, out_pc_32); end
    endtask

    task automatic test_flush();
        tick(1'b1, 32'h00700113, 64'h300, 1'b0, 1'b0);
        tick(1'b1, 32'h123451B7, 64'h304, 1'b0, 1'b0);
        tick(1'b1, 32'h00000013, 64'h308, 1'b0, 1'b1);
        n_cmp++; if ({out_valid_32, in_ready_32} !== 2'b01) begin n_fail++; $display("[TB] FAIL flush_state: valid %b ready %b want 0 1", out_valid_32, in_ready_32); end
        tick(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        n_cmp++; if (out_valid_32 !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_drop_push: out_valid %b want 0", out_valid_32); end
    endtask

    task automatic test_xlen64();
        tick(1'b1, 32'h800000B7, 64'h8000_0000_0000_0010, 1'b0, 1'b0);
        n_cmp++; if ({fmt_64, imm_64} !== {3'd4, 64'hFFFFFFFF80000000}) begin n_fail++; $display("[TB] FAIL rv64_lui: fmt %0d imm %h want 4 ffffffff80000000", fmt_64, imm_64); end
        n_cmp++; if (out_pc_64 !== 64'h8000_0000_0000_0010) begin n_fail++; $display("[TB] FAIL rv64_pc: got %h", out_pc_64); end
        n_cmp++; if ({fmt_32, imm_32} !== {3'd4, 32'h80000000}) begin n_fail++; $display("[TB] FAIL rv32_lui: fmt %0d imm %h want 4 80000000", fmt_32, imm_32); end
        tick(1'b1, 32'h0000001B, 64'h14, 1'b1, 1'b0);
        n_cmp++; if (fmt_64 !== 3'd1) begin n_fail++; $display("[TB] FAIL rv64_opimm32: fmt %0d want 1", fmt_64); end
        n_cmp++; if (fmt_32 !== 3'd7) begin n_fail++; $display("[TB] FAIL rv32_opimm32: fmt %0d want 7", fmt_32); end
        tick(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        tick(1'b1, 32'h00000000, 64'h400, 1'b1, 1'b0);
        n_cmp++; if ({illegal_32, fmt_32, rd_en_32} !== {ILL_EN, 3'd7, 1'b0}) begin n_fail++; $display("[TB] FAIL zero_instr: illegal %b fmt %0d rd_en %b want %b 7 0", illegal_32, fmt_32, rd_en_32, ILL_EN); end
        tick(1'b1, 32'h00000073, 64'h404, 1'b1, 1'b0);
        n_cmp++; if ({illegal_32, fmt_32, rs1_en_32} !== {1'b0, 3'd1, 1'b1}) begin n_fail++; $display("[TB] FAIL ecall: illegal %b fmt %0d rs1_en %b want 0 1 1", illegal_32, fmt_32, rs1_en_32); end
        tick(1'b1, 32'h30200073, 64'h408, 1'b1, 1'b0);
        n_cmp++; if ({illegal_32, rs1_en_32} !== {ILL_EN, !ILL_EN}) begin n_fail++; $display("[TB] FAIL system_other: illegal %b rs1_en %b want %b %b", illegal_32, rs1_en_32, ILL_EN, !ILL_EN); end
        tick(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        tick(1'b1, 32'h00500093, 64'h500, 1'b0, 1'b0);
        rst = 1'b1;
        tick(1'b1, 32'h00700113, 64'h504, 1'b0, 1'b1);
        rst = 1'b0;
        n_cmp++; if ({out_valid_32, in_ready_32, out_pc_32, fmt_32, imm_32, rd_32} !== {2'b01, 32'h0, 3'd0, 32'h0, 5'd0}) begin n_fail++; $display("[TB] FAIL mid_reset: valid %b ready %b pc %h fmt %0d imm %h", out_valid_32, in_ready_32, out_pc_32, fmt_32, imm_32); end
    endtask

    task automatic test_random();
        ent_t        q[$];
        ent_t        shown;
        ent_t        ent;
        bit          shown_set;
        exp_t        e32, e64;
        logic [31:0] ins, r, ins_n;
        logic [63:0] pc, pc_n;
        logic [6:0]  op;
        logic        v, ordy, fl;
        bit          can_push;
        rst = 1'b1;
        tick(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        rst = 1'b0;
        shown_set = 1'b0;
        shown = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (shown_set) begin
                ins = shown.ins; pc = shown.pc;
                e32 = model_decode(ins, 1'b0); e64 = model_decode(ins, 1'b1);
            end else begin
                ins = 32'h0; pc = 64'h0; e32 = '0; e64 = '0;
            end
            n_cmp++; if ({out_valid_32, in_ready_32, out_valid_64, in_ready_64} !== {q.size() != 0, q.size() < DEPTH, q.size() != 0, q.size() < DEPTH}) begin n_fail++; $display("[TB] FAIL rnd_hs cyc %0d: v32 %b r32 %b v64 %b r64 %b want size %0d", cyc, out_valid_32, in_ready_32, out_valid_64, in_ready_64, q.size()); end
            n_cmp++; if ({out_pc_32, out_pc_64} !== {pc[31:0], pc}) begin n_fail++; $display("[TB] FAIL rnd_pc cyc %0d: got %h %h want %h", cyc, out_pc_32, out_pc_64, pc); end
            n_cmp++; if ({rs1_32, rs2_32, rd_32, func3_32, func7_32, opcode_32} !== {ins[19:15], ins[24:20], ins[11:7], ins[14:12], ins[31:25], ins[6:0]}) begin n_fail++; $display("[TB] FAIL rnd_fields32 cyc %0d: instr %h opcode %h", cyc, ins, opcode_32); end
            n_cmp++; if ({rs1_64, rs2_64, rd_64, func3_64, func7_64, opcode_64} !== {ins[19:15], ins[24:20], ins[11:7], ins[14:12], ins[31:25], ins[6:0]}) begin n_fail++; $display("[TB] FAIL rnd_fields64 cyc %0d: instr %h opcode %h", cyc, ins, opcode_64); end
            n_cmp++; if ({fmt_32, imm_32} !== {e32.fmt, e32.imm[31:0]}) begin n_fail++; $display("[TB] FAIL rnd_dec32 cyc %0d instr %h: fmt %0d imm %h want %0d %h", cyc, ins, fmt_32, imm_32, e32.fmt, e32.imm[31:0]); end
            n_cmp++; if ({fmt_64, imm_64} !== {e64.fmt, e64.imm}) begin n_fail++; $display("[TB] FAIL rnd_dec64 cyc %0d instr %h: fmt %0d imm %h want %0d %h", cyc, ins, fmt_64, imm_64, e64.fmt, e64.imm); end
            n_cmp++; if ({rs1_en_32, rs2_en_32, rd_en_32, illegal_32} !== {e32.rs1_en, e32.rs2_en, e32.rd_en, e32.illegal}) begin n_fail++; $display("[TB] FAIL rnd_flags32 cyc %0d instr %h: got %b want %b", cyc, ins, {rs1_en_32, rs2_en_32, rd_en_32, illegal_32}, {e32.rs1_en, e32.rs2_en, e32.rd_en, e32.illegal}); end
            n_cmp++; if ({rs1_en_64, rs2_en_64, rd_en_64, illegal_64} !== {e64.rs1_en, e64.rs2_en, e64.rd_en, e64.illegal}) begin n_fail++; $display("[TB] FAIL rnd_flags64 cyc %0d instr %h: got %b want %b", cyc, ins, {rs1_en_64, rs2_en_64, rd_en_64, illegal_64}, {e64.rs1_en, e64.rs2_en, e64.rd_en, e64.illegal}); end

            r     = $urandom();
            op    = op_pool[$urandom_range(0, 13)];
            ins_n = {r[31:7], op};
            if (op == 7'h73 && r[0]) begin
                ins_n[31:20] = {11'b0, r[1]};
                ins_n[14:12] = 3'b0;
            end
            pc_n = {$urandom(), $urandom()};
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            tick(v, ins_n, pc_n, ordy, fl);

            if (fl) begin
                q.delete();
            end else begin
                can_push = (q.size() < DEPTH);
                if (q.size() > 0 && ordy) begin
                    ent = q.pop_front();
                end
                if (v && can_push) begin
                    ent.pc = pc_n; ent.ins = ins_n;
                    q.push_back(ent);
                end
            end
            if (q.size() > 0) begin
                shown = q[0];
                shown_set = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 64'h0; in_instr = 32'h0;
        @(negedge clk);
        test_reset();
        test_addi();
        test_sw();
        test_full_backpressure();
        test_flush();
        test_xlen64();
        test_illegal();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
